// File: rtl/alu_pipe_if.sv
// Handshake/operand bundle between the operand sequencer (master) and alu_pipe (slave).
interface alu_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       oc;
    logic             acc_mode;
    logic             acc_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic [3:0]       flags;

    // Sequencer side: issues operations and consumes results.
    modport master (
        output in_valid, oc, acc_mode, acc_clr, a, b, out_ready,
        input  in_ready, out_valid, f, flags
    );

    // ALU side: accepts operations and produces results.
    modport slave (
        input  in_valid, oc, acc_mode, acc_clr, a, b, out_ready,
        output in_ready, out_valid, f, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, single output register and an
// optional accumulator that can stand in for operand a.
module alu_pipe #(
    parameter int WIDTH    = 4,
    parameter int ACC_INIT = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam logic [WIDTH-1:0] ACC_INIT_V = WIDTH'(ACC_INIT);

    logic [WIDTH-1:0] f_reg;
    logic [3:0]       flags_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] acc_reg;

    logic [WIDTH-1:0] x;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_next;
    logic             c_next;
    logic             v_next;
    logic [3:0]       flags_next;

    logic accept;
    logic pop;

    // The output register may refill in the same cycle it is drained, so a
    // stall only happens while a result is waiting and downstream refuses it.
    assign bus.in_ready  = !out_valid_reg || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = out_valid_reg && bus.out_ready;

    assign bus.out_valid = out_valid_reg;
    assign bus.f         = f_reg;
    assign bus.flags     = flags_reg;

    // Operand select, result and carry/overflow for the current opcode.
    always_comb begin
        x        = bus.acc_mode ? acc_reg : bus.a;
        sum      = {1'b0, x} + {1'b0, bus.b};
        diff     = {1'b0, x} - {1'b0, bus.b};
        res_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        case (bus.oc)
            OP_ADD: begin
                res_next = sum[WIDTH-1:0];
                c_next   = sum[WIDTH];
                // Same-sign operands producing a result of the other sign.
                v_next   = (x[WIDTH-1] == bus.b[WIDTH-1]) &&
                           (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                res_next = diff[WIDTH-1:0];
                // The extra bit of the widened difference is the borrow (x < b).
                c_next   = diff[WIDTH];
                // Opposite-sign operands where the result sign departs from x.
                v_next   = (x[WIDTH-1] != bus.b[WIDTH-1]) &&
                           (diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: res_next = x & bus.b;
            OP_OR:  res_next = x | bus.b;
            OP_XOR: res_next = x ^ bus.b;
            OP_NOT: res_next = ~x;
            OP_SHL: begin
                res_next = {x[WIDTH-2:0], 1'b0};
                c_next   = x[WIDTH-1];
            end
            OP_SHR: begin
                res_next = {1'b0, x[WIDTH-1:1]};
                c_next   = x[0];
            end
            default: begin
                res_next = '0;
                c_next   = 1'b0;
                v_next   = 1'b0;
            end
        endcase
        flags_next = {res_next[WIDTH-1], (res_next == '0), c_next, v_next};
    end

    // Output register: load on accept, drop valid on a pop that is not refilled,
    // otherwise hold so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            f_reg         <= '0;
            flags_reg     <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            f_reg         <= res_next;
            flags_reg     <= flags_next;
        end else if (pop) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Accumulator: tracks every accepted result; a clear only lands on a cycle
    // with no accept, so an accept (even one reading acc) always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= ACC_INIT_V;
        end else if (accept) begin
            acc_reg <= res_next;
        end else if (bus.acc_clr) begin
            acc_reg <= ACC_INIT_V;
        end
    end
endmodule
